// File: rtl/icrefill.sv
// Icache line refill: one miss at a time, critical-word-first burst, writes data array then tag/valid.
// Latency: each accepted beat is written to the data array on the following cycle; tag write and fill_done in the cycle after the last beat.
// Backpressure: miss_rdy only in IDLE, mem_req_val held until mem_req_rdy; optional crit word forwarding under ICREFILL_CRIT_FWD_EN.
module icrefill #(
   parameter int WORDS      = 1024,
   parameter int LINE_WORDS = 8,
   parameter int IDX_W      = $clog2(WORDS),
   parameter int OFF_W      = $clog2(LINE_WORDS),
   parameter int LINE_IDX_W = IDX_W - OFF_W,
   parameter int TAG_W      = 30 - IDX_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  miss_val,
   input  logic [31:0]           miss_adr,
   output logic                  miss_rdy,
   output logic                  mem_req_val,
   input  logic                  mem_req_rdy,
   output logic [31:0]           mem_req_adr,
   input  logic                  mem_rsp_val,
   input  logic [31:0]           mem_rsp_dat,
   input  logic                  mem_rsp_err,
   output logic [3:0]            dat_wr_en,
   output logic [IDX_W-1:0]      dat_wr_adr,
   output logic [31:0]           dat_wr_dat,
   output logic                  tag_wr_en,
   output logic [LINE_IDX_W-1:0] tag_wr_idx,
   output logic [TAG_W-1:0]      tag_wr_tag,
   output logic                  tag_wr_val,
`ifdef ICREFILL_CRIT_FWD_EN
   output logic                  crit_val,
   output logic [31:0]           crit_dat,
`endif
   output logic                  fill_done,
   output logic                  fill_err,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_FILL  = 3'd2,
      S_DONE  = 3'd3,
      S_ABORT = 3'd4
   } state_t;

   // Counter value held when the final beat of the line arrives.
   localparam logic [OFF_W:0] LAST_BEAT = (OFF_W+1)'(LINE_WORDS - 1);

   state_t                state_q, state_d;
   logic [OFF_W:0]        cnt_q, cnt_d;
   logic [OFF_W-1:0]      ptr_q, ptr_d;
   logic [LINE_IDX_W-1:0] idx_q, idx_d;
   logic [TAG_W-1:0]      tag_q, tag_d;
   logic [3:0]            dat_wr_en_q, dat_wr_en_d;
   logic [IDX_W-1:0]      dat_wr_adr_q, dat_wr_adr_d;
   logic [31:0]           dat_wr_dat_q, dat_wr_dat_d;
   logic                  beat_ok;
   logic                  unused_adr_lsb;

   // Byte-offset bits never matter: fills are whole words.
   assign unused_adr_lsb = ^miss_adr[1:0];

   // Next-state, latch capture and registered data-array write computation.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ptr_d        = ptr_q;
      idx_d        = idx_q;
      tag_d        = tag_q;
      dat_wr_en_d  = 4'b0000;
      dat_wr_adr_d = dat_wr_adr_q;
      dat_wr_dat_d = dat_wr_dat_q;
      beat_ok      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (miss_val) begin
               idx_d   = miss_adr[IDX_W+1:OFF_W+2];
               ptr_d   = miss_adr[OFF_W+1:2];
               tag_d   = miss_adr[31:IDX_W+2];
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // Responses are ignored until the request handshake has completed.
            if (mem_req_rdy) begin
               cnt_d   = '0;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (mem_rsp_val) begin
               if (mem_rsp_err) begin
                  state_d = S_ABORT;
               end else begin
                  beat_ok      = 1'b1;
                  dat_wr_en_d  = 4'b1111;
                  dat_wr_adr_d = {idx_q, ptr_q};
                  dat_wr_dat_d = mem_rsp_dat;
                  // Pointer wraps inside the line; the index is never touched.
                  ptr_d        = ptr_q + OFF_W'(1);
                  cnt_d        = cnt_q + (OFF_W+1)'(1);
                  if (cnt_q == LAST_BEAT) state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ABORT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, latched miss fields and data-array write port registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         ptr_q        <= '0;
         idx_q        <= '0;
         tag_q        <= '0;
         dat_wr_en_q  <= 4'b0000;
         dat_wr_adr_q <= '0;
         dat_wr_dat_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
         idx_q        <= idx_d;
         tag_q        <= tag_d;
         dat_wr_en_q  <= dat_wr_en_d;
         dat_wr_adr_q <= dat_wr_adr_d;
         dat_wr_dat_q <= dat_wr_dat_d;
      end
   end

`ifdef ICREFILL_CRIT_FWD_EN
   logic        crit_val_q, crit_val_d;
   logic [31:0] crit_dat_q, crit_dat_d;

   // First accepted beat of a fill is forwarded alongside its array write.
   always_comb begin
      crit_val_d = beat_ok && (cnt_q == '0);
      crit_dat_d = crit_val_d ? mem_rsp_dat : crit_dat_q;
   end

   // Critical word forwarding registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crit_val_q <= 1'b0;
         crit_dat_q <= '0;
      end else begin
         crit_val_q <= crit_val_d;
         crit_dat_q <= crit_dat_d;
      end
   end

   assign crit_val = crit_val_q;
   assign crit_dat = crit_dat_q;
`else
   logic unused_beat_ok;
   assign unused_beat_ok = beat_ok;
`endif

   // Handshake and tag-port outputs decoded straight from the state register.
   always_comb begin
      miss_rdy    = (state_q == S_IDLE);
      busy        = (state_q != S_IDLE);
      mem_req_val = (state_q == S_REQ);
      mem_req_adr = {tag_q, idx_q, ptr_q, 2'b00};
      tag_wr_en   = (state_q == S_DONE) || (state_q == S_ABORT);
      tag_wr_val  = (state_q == S_DONE);
      tag_wr_idx  = idx_q;
      tag_wr_tag  = tag_q;
      fill_done   = (state_q == S_DONE);
      fill_err    = (state_q == S_ABORT);
   end

   assign dat_wr_en  = dat_wr_en_q;
   assign dat_wr_adr = dat_wr_adr_q;
   assign dat_wr_dat = dat_wr_dat_q;

endmodule

// File: tb/tb_icrefill.sv
// Directed bench for icrefill: reset, aligned, wrapped, gapped, error and mid-fill reset fills.
// Stimulus and checks at negedge+1; a negedge monitor records array/tag writes and pulses.
// Expected addresses and data are hand-computed constants per scenario.
module tb_icrefill;

   typedef logic [9:0] adr_arr_t [8];

   logic        clk;
   logic        rst_n;
   logic        miss_val;
   logic [31:0] miss_adr;
   logic        miss_rdy;
   logic        mem_req_val;
   logic        mem_req_rdy;
   logic [31:0] mem_req_adr;
   logic        mem_rsp_val;
   logic [31:0] mem_rsp_dat;
   logic        mem_rsp_err;
   logic [3:0]  dat_wr_en;
   logic [9:0]  dat_wr_adr;
   logic [31:0] dat_wr_dat;
   logic        tag_wr_en;
   logic [6:0]  tag_wr_idx;
   logic [19:0] tag_wr_tag;
   logic        tag_wr_val;
   logic        fill_done;
   logic        fill_err;
   logic        busy;
`ifdef ICREFILL_CRIT_FWD_EN
   logic        crit_val;
   logic [31:0] crit_dat;
`endif

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;

   logic [9:0]  wq_adr [$];
   logic [31:0] wq_dat [$];
   logic [3:0]  wq_en  [$];
   int          wq_cyc [$];
   int          bq     [$];
   int          n_tag, n_done, n_errp, n_crit, done_cyc;
   logic [6:0]  t_idx;
   logic [19:0] t_tag;
   logic        t_val;
   logic [31:0] crit_seen;

   icrefill dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .miss_val    (miss_val),
      .miss_adr    (miss_adr),
      .miss_rdy    (miss_rdy),
      .mem_req_val (mem_req_val),
      .mem_req_rdy (mem_req_rdy),
      .mem_req_adr (mem_req_adr),
      .mem_rsp_val (mem_rsp_val),
      .mem_rsp_dat (mem_rsp_dat),
      .mem_rsp_err (mem_rsp_err),
      .dat_wr_en   (dat_wr_en),
      .dat_wr_adr  (dat_wr_adr),
      .dat_wr_dat  (dat_wr_dat),
      .tag_wr_en   (tag_wr_en),
      .tag_wr_idx  (tag_wr_idx),
      .tag_wr_tag  (tag_wr_tag),
      .tag_wr_val  (tag_wr_val),
`ifdef ICREFILL_CRIT_FWD_EN
      .crit_val    (crit_val),
      .crit_dat    (crit_dat),
`endif
      .fill_done   (fill_done),
      .fill_err    (fill_err),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Record everything the DUT writes, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dat_wr_en != 4'b0000) begin
            wq_adr.push_back(dat_wr_adr);
            wq_dat.push_back(dat_wr_dat);
            wq_en.push_back(dat_wr_en);
            wq_cyc.push_back(cyc);
         end
         if (tag_wr_en) begin
            n_tag++;
            t_idx = tag_wr_idx;
            t_tag = tag_wr_tag;
            t_val = tag_wr_val;
         end
         if (fill_done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (fill_err) n_errp++;
`ifdef ICREFILL_CRIT_FWD_EN
         if (crit_val) begin
            n_crit++;
            crit_seen = crit_dat;
         end
`endif
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      wq_adr.delete();
      wq_dat.delete();
      wq_en.delete();
      wq_cyc.delete();
      bq.delete();
      n_tag = 0; n_done = 0; n_errp = 0; n_crit = 0; done_cyc = -1;
      t_idx = '0; t_tag = '0; t_val = 1'b0; crit_seen = '0;
   endtask

   // One complete miss: request handshake after req_dly stall cycles, then
   // the response pattern (bit i = beat valid in cycle i) until 8 beats or an error.
   task automatic run_fill(input logic [31:0] adr, input int req_dly, input logic [31:0] d0,
                           input logic [31:0] pat, input int npat, input int err_beat);
      int   beats;
      logic errd;
      logic v;
      beats = 0;
      errd  = 1'b0;
      step();
      miss_adr = adr;
      miss_val = 1'b1;
      step();
      miss_val = 1'b0;
      miss_adr = 32'hFFFF_FFFF;
      chk("req_val", {31'd0, mem_req_val}, 32'd1);
      chk("req_adr", mem_req_adr, {adr[31:2], 2'b00});
      for (int d = 0; d < req_dly; d++) begin
         mem_rsp_val = 1'b1;
         mem_rsp_dat = 32'hDEAD_0000 + d;
         step();
         chk("req_hold_val", {31'd0, mem_req_val}, 32'd1);
         chk("req_hold_adr", mem_req_adr, {adr[31:2], 2'b00});
      end
      mem_req_rdy = 1'b1;
      mem_rsp_val = 1'b1;
      mem_rsp_dat = 32'hDEAD_BEEF;
      step();
      mem_req_rdy = 1'b0;
      for (int i = 0; i < npat && beats < 8 && !errd; i++) begin
         v = pat[i];
         mem_rsp_val = v;
         mem_rsp_dat = d0 + beats;
         mem_rsp_err = v && (beats == err_beat);
         if (v) begin
            if (beats == err_beat) errd = 1'b1;
            else begin
               bq.push_back(cyc);
               beats++;
            end
         end
         step();
      end
      mem_rsp_val = 1'b0;
      mem_rsp_err = 1'b0;
      for (int w = 0; w < 4 && !(fill_done || fill_err); w++) step();
      chk("fill_end_seen", {31'd0, fill_done | fill_err}, 32'd1);
      chk("busy_at_end", {31'd0, miss_rdy}, 32'd0);
   endtask

   task automatic check_writes(input string tag, input adr_arr_t ea, input logic [31:0] d0, input int n);
      chk({tag, "_nwr"}, wq_adr.size(), n);
      for (int i = 0; i < n && i < wq_adr.size(); i++) begin
         chk({tag, "_adr"}, {22'd0, wq_adr[i]}, {22'd0, ea[i]});
         chk({tag, "_dat"}, wq_dat[i], d0 + i);
         chk({tag, "_en"},  {28'd0, wq_en[i]}, 32'hF);
         if (i < bq.size()) chk({tag, "_lat"}, wq_cyc[i], bq[i] + 1);
      end
   endtask

   initial begin
      adr_arr_t ea;
      rst_n       = 1'b0;
      miss_val    = 1'b0;
      miss_adr    = '0;
      mem_req_rdy = 1'b0;
      mem_rsp_val = 1'b0;
      mem_rsp_dat = '0;
      mem_rsp_err = 1'b0;
      clear_mon();

      // 1. reset held while inputs toggle
      for (int i = 0; i < 3; i++) begin
         step();
         miss_val    = ~miss_val;
         miss_adr    = 32'h1234_5678 ^ i;
         mem_req_rdy = ~mem_req_rdy;
         mem_rsp_val = ~mem_rsp_val;
         mem_rsp_err = ~mem_rsp_err;
      end
      step();
      chk("rst_miss_rdy", {31'd0, miss_rdy}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_dat_wr_en", {28'd0, dat_wr_en}, 32'd0);
      chk("rst_tag_wr_en", {31'd0, tag_wr_en}, 32'd0);
      chk("rst_fill_done", {31'd0, fill_done}, 32'd0);
      chk("rst_fill_err", {31'd0, fill_err}, 32'd0);
      chk("rst_req_val", {31'd0, mem_req_val}, 32'd0);
      miss_val = 1'b0; mem_req_rdy = 1'b0; mem_rsp_val = 1'b0; mem_rsp_err = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("idle_miss_rdy", {31'd0, miss_rdy}, 32'd1);

      // 2. aligned miss 0x1040, request stalled 3 cycles, beats A0..A7
      clear_mon();
      run_fill(32'h0000_1040, 3, 32'hA0, 32'hFF, 8, -1);
      ea = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h016, 10'h017};
      check_writes("aligned", ea, 32'hA0, 8);
      chk("aligned_ntag", n_tag, 1);
      chk("aligned_tag_idx", {25'd0, t_idx}, 32'd2);
      chk("aligned_tag_tag", {12'd0, t_tag}, 32'h00001);
      chk("aligned_tag_val", {31'd0, t_val}, 32'd1);
      chk("aligned_ndone", n_done, 1);
      chk("aligned_done_lat", done_cyc, bq[7] + 1);
      step();
      chk("aligned_miss_rdy_back", {31'd0, miss_rdy}, 32'd1);

      // 3. wrapping miss 0x105C, beats B0..B7
      clear_mon();
      run_fill(32'h0000_105C, 0, 32'hB0, 32'hFF, 8, -1);
      ea = '{10'h017, 10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h016};
      check_writes("wrap", ea, 32'hB0, 8);
      chk("wrap_tag_idx", {25'd0, t_idx}, 32'd2);
      chk("wrap_ndone", n_done, 1);
`ifdef ICREFILL_CRIT_FWD_EN
      chk("wrap_ncrit", n_crit, 1);
      chk("wrap_crit_dat", crit_seen, 32'hB0);
`endif
      step();

      // 4. gapped response 1,0,0,1,1,0,1,1,1,0,1,1 on miss 0x2080, beats C0..C7
      clear_mon();
      run_fill(32'h0000_2080, 1, 32'hC0, 32'h0000_0DD9, 12, -1);
      ea = '{10'h020, 10'h021, 10'h022, 10'h023, 10'h024, 10'h025, 10'h026, 10'h027};
      check_writes("gap", ea, 32'hC0, 8);
      chk("gap_ndone", n_done, 1);
      chk("gap_done_lat", done_cyc, bq[7] + 1);
      chk("gap_tag_idx", {25'd0, t_idx}, 32'd4);
      chk("gap_tag_tag", {12'd0, t_tag}, 32'h00002);
      step();

      // 5. error on beat 3 of miss 0x3000_0064 (idx 3, ptr 1, tag 0x30000)
      clear_mon();
      run_fill(32'h3000_0064, 0, 32'hD0, 32'hFF, 8, 3);
      ea = '{10'h019, 10'h01A, 10'h01B, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
      check_writes("err", ea, 32'hD0, 3);
      chk("err_ntag", n_tag, 1);
      chk("err_tag_val", {31'd0, t_val}, 32'd0);
      chk("err_tag_idx", {25'd0, t_idx}, 32'd3);
      chk("err_tag_tag", {12'd0, t_tag}, 32'h30000);
      chk("err_nerrp", n_errp, 1);
      chk("err_ndone", n_done, 0);
      step();
      chk("err_miss_rdy_back", {31'd0, miss_rdy}, 32'd1);

      // 6. reset after 4 beats, then a fresh fill
      clear_mon();
      step();
      miss_adr = 32'h0000_1040;
      miss_val = 1'b1;
      step();
      miss_val = 1'b0;
      chk("mid_req_val", {31'd0, mem_req_val}, 32'd1);
      mem_req_rdy = 1'b1;
      step();
      mem_req_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_rsp_val = 1'b1;
         mem_rsp_dat = 32'hE0 + i;
         step();
      end
      mem_rsp_val = 1'b0;
      chk("mid_wr_before_rst", {28'd0, dat_wr_en}, 32'hF);
      chk("mid_adr_before_rst", {22'd0, dat_wr_adr}, 32'h013);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr_en", {28'd0, dat_wr_en}, 32'd0);
      chk("mid_rst_tag_wr_en", {31'd0, tag_wr_en}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("mid_ntag", n_tag, 0);
      chk("mid_ndone", n_done, 0);
      clear_mon();
      run_fill(32'h0000_1040, 1, 32'hF0, 32'hFF, 8, -1);
      ea = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h016, 10'h017};
      check_writes("fresh", ea, 32'hF0, 8);
      chk("fresh_ndone", n_done, 1);
      chk("fresh_tag_val", {31'd0, t_val}, 32'd1);
      step();
      chk("fresh_miss_rdy_back", {31'd0, miss_rdy}, 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/icrefill.md
Name: icrefill

Overview:
- Instruction-cache line refill engine. It is the writer side of the icache data array.
- Accepts one miss at a time from fetch and issues a single critical-word-first burst request to memory.
- Writes returned words into the data array through its byte-enable write port (wr_en/wr_adr/wr_dat style), then writes the tag/valid entry and signals fetch.

Parameters:
- WORDS, 1024: data array depth in 32-bit words. Power of two. IDX_W = log2(WORDS) = 10.
- LINE_WORDS, 8: words per line. Power of two, 2..32. OFF_W = log2(LINE_WORDS) = 3.
- Derived: LINE_IDX_W = IDX_W - OFF_W = 7; TAG_W = 30 - IDX_W = 20.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous reset, active-low.
- miss_val  in  1  miss request from fetch.
- miss_adr  in  32  miss byte address.
- miss_rdy  out  1  high only in IDLE.
- mem_req_val  out  1  burst request valid.
- mem_req_rdy  in  1  memory accepts request.
- mem_req_adr  out  32  critical word address, {miss_adr[31:2],2'b00}.
- mem_rsp_val  in  1  response beat valid.
- mem_rsp_dat  in  32  beat data.
- mem_rsp_err  in  1  beat error; memory ends the burst on error.
- dat_wr_en  out  4  byte write enables to the data array.
- dat_wr_adr  out  IDX_W  data array word address.
- dat_wr_dat  out  32  data array write data.
- tag_wr_en  out  1  tag array write strobe.
- tag_wr_idx  out  LINE_IDX_W  line index.
- tag_wr_tag  out  TAG_W  tag value.
- tag_wr_val  out  1  valid bit written into the tag entry.
- fill_done  out  1  one-cycle pulse: line valid.
- fill_err  out  1  one-cycle pulse: fill aborted.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; beat counter = 0.
  - All registered outputs = 0. miss_rdy = 1.
- States: IDLE, REQ, FILL, DONE, ABORT.
- IDLE:
  - miss_val && miss_rdy latches miss_adr[31:2] and moves to REQ.
  - Latched fields: line index = adr[IDX_W+1:OFF_W+2]; pointer = adr[OFF_W+1:2]; tag = adr[31:IDX_W+2].
- REQ:
  - mem_req_val = 1 with a stable mem_req_adr until mem_req_rdy is sampled high.
  - On that cycle go to FILL; counter = 0.
  - mem_rsp_val is ignored in REQ and in the handshake cycle.
- FILL:
  - Each cycle with mem_rsp_val = 1 and mem_rsp_err = 0 is an accepted beat.
  - Next cycle after an accepted beat: dat_wr_en = 4'b1111, dat_wr_adr = {line index, pointer}, dat_wr_dat = beat data.
  - After each beat: pointer increments modulo LINE_WORDS (wraps inside the line, never carries into the index); counter increments.
  - Cycles with mem_rsp_val = 0 produce no write (dat_wr_en = 0).
  - The beat that makes counter = LINE_WORDS moves the state to DONE.
- DONE (one cycle):
  - The last data write occurs in this cycle.
  - tag_wr_en = 1, tag_wr_val = 1, fill_done = 1.
  - Next state IDLE; miss_rdy returns the following cycle.
- ABORT:
  - Entered when mem_rsp_val && mem_rsp_err in FILL. The error beat is not written.
  - Earlier beats have already been written.
  - One cycle: tag_wr_en = 1, tag_wr_val = 0 (invalidates the line), fill_err = 1, then IDLE.
- tag_wr_idx and tag_wr_tag hold the latched values whenever tag_wr_en = 1.
- One fill outstanding at a time. miss_val during busy is not accepted; the requester holds it.
- Reset mid-fill:
  - Strobes drop immediately.
  - The partial line is left unvalidated; tag array validity reset is owned by the tag array.
- No combinational path from mem_rsp_* to dat_wr_*.

Optional Feature:
- Macro: ICREFILL_CRIT_FWD_EN.
- Defined:
  - Adds outputs crit_val (1) and crit_dat (32).
  - crit_val pulses for exactly one cycle, coincident with the write of the first accepted beat (the critical word). crit_dat = that word.
  - Lets fetch restart before fill_done.
- Undefined: no such ports; fetch waits for fill_done.
- Core behaviour is identical in both builds.

Test Plan:
1. Reset:
   - Stimulus: hold rst_n = 0, toggle inputs.
   - Required: miss_rdy = 1, busy = 0; dat_wr_en, tag_wr_en, fill_done, fill_err, mem_req_val all 0.
2. Aligned miss:
   - Stimulus: miss_adr = 0x0000_1040; mem_req_rdy delayed 3 cycles; 8 back-to-back beats 0xA0..0xA7.
   - Required: mem_req_adr = 0x0000_1040; writes at 0x010..0x017 with data 0xA0..0xA7; then tag_wr_idx = 2, tag_wr_tag = 0x00001, tag_wr_val = 1, fill_done pulse; miss_rdy back 1 cycle later.
3. Wrap:
   - Stimulus: miss_adr = 0x0000_105C; beats B0..B7.
   - Required: writes at 0x017, 0x010, 0x011 … 0x016 in that order; tag_wr_idx = 2.
4. Gapped response:
   - Stimulus: mem_rsp_val pattern 1,0,0,1,1,0,1,1,1,0,1,1.
   - Required: exactly 8 writes, each one cycle after its beat; fill_done one cycle after the 8th beat.
5. Error:
   - Stimulus: err on beat 3 (0-based).
   - Required: 3 writes only; tag_wr_en = 1 with tag_wr_val = 0 and fill_err pulse; next miss accepted from IDLE.
6. Reset mid-fill:
   - Stimulus: assert rst_n = 0 after 4 beats.
   - Required: dat_wr_en = 0 in the same cycle with no tag write. A new miss after release issues a fresh mem_req with counter = 0.
   - With ICREFILL_CRIT_FWD_EN: crit_val pulses once with B0 in the scenario 3 fill.
